// File: rtl/mul32_seq_enet_nios.sv
// 32x32->64 multiply sequencer for a Nios custom instruction, driving an external 2-stage 16x16 multiplier.
// Optional feature macro: MUL32_SIGNED_EN (n[1] selects two's-complement operands).
module mul32_seq_enet_nios (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [1:0]  n,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] mul_dataa,
  output logic [15:0] mul_datab,
  output logic        mul_clken,
  input  logic [31:0] mul_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, b_reg;
  logic        hi_sel_reg;
  logic [2:0]  ret_cnt_reg, ret_cnt_next;
  logic [2:0]  ret_off;
  logic [63:0] acc_reg, acc_next, acc_init;
  logic [31:0] result_reg, result_next;
  logic [63:0] pp_shift [4];

  // Pair k lands two enabled cycles after it was issued; shift by its weight.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      localparam int SHIFT = 16 * ((gi >> 1) + (gi & 1));
      assign pp_shift[gi] = {32'd0, mul_result} << SHIFT;
    end
  endgenerate

  assign ret_off = ret_cnt_reg - 3'd2;

`ifdef MUL32_SIGNED_EN
  logic [31:0] corr;
  always_comb begin
    corr = (dataa[31] ? datab : 32'd0) + (datab[31] ? dataa : 32'd0);
    acc_init = n[1] ? {32'd0 - corr, 32'd0} : 64'd0;
  end
`else
  logic unused_n1;
  assign unused_n1 = n[1];
  assign acc_init  = 64'd0;
`endif

  always_comb begin
    state_next   = state_reg;
    ret_cnt_next = ret_cnt_reg;
    acc_next     = acc_reg;
    result_next  = result_reg;
    mul_clken    = 1'b0;
    mul_dataa    = 16'd0;
    mul_datab    = 16'd0;
    done         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_ISSUE;
          ret_cnt_next = 3'd0;
          acc_next     = acc_init;
        end
      end
      S_ISSUE: begin
        mul_clken    = clk_en & ~reset;
        mul_dataa    = ret_cnt_reg[1] ? a_reg[31:16] : a_reg[15:0];
        mul_datab    = ret_cnt_reg[0] ? b_reg[31:16] : b_reg[15:0];
        ret_cnt_next = ret_cnt_reg + 3'd1;
        if (ret_cnt_reg >= 3'd2)
          acc_next = acc_reg + pp_shift[ret_off[1:0]];
        if (ret_cnt_reg == 3'd3)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        mul_clken    = clk_en & ~reset;
        ret_cnt_next = ret_cnt_reg + 3'd1;
        acc_next     = acc_reg + pp_shift[ret_off[1:0]];
        if (ret_cnt_reg == 3'd5) begin
          state_next  = S_DONE;
          result_next = hi_sel_reg ? acc_next[63:32] : acc_next[31:0];
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // clk_en freezes everything, so multiplier latency stays aligned in enabled edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      hi_sel_reg  <= 1'b0;
      ret_cnt_reg <= 3'd0;
      acc_reg     <= 64'd0;
      result_reg  <= 32'd0;
    end else if (clk_en) begin
      state_reg   <= state_next;
      ret_cnt_reg <= ret_cnt_next;
      acc_reg     <= acc_next;
      result_reg  <= result_next;
      if (state_reg == S_IDLE && start) begin
        a_reg      <= dataa;
        b_reg      <= datab;
        hi_sel_reg <= n[0];
      end
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_mul32_seq_enet_nios.sv
// Directed bench for mul32_seq_enet_nios with a behavioural 2-stage clken-gated 16x16 multiplier.
module tb_mul32_seq_enet_nios;
  logic        clock = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic [1:0]  n;
  logic        done;
  logic [31:0] result;
  logic [15:0] mul_dataa, mul_datab;
  logic        mul_clken;
  logic [31:0] mul_result;
  logic [31:0] mul_s1_reg, mul_s2_reg;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mul32_seq_enet_nios dut (
    .clock(clock), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .done(done), .result(result),
    .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_clken(mul_clken),
    .mul_result(mul_result)
  );

  always @(posedge clock) begin
    if (mul_clken) begin
      mul_s1_reg <= 32'(mul_dataa) * 32'(mul_datab);
      mul_s2_reg <= mul_s1_reg;
    end
  end
  assign mul_result = mul_s2_reg;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  // One operation; cycle c is measured from the cycle start was presented (T).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] nn,
                        input int stall_at, input int stall_len, input int busy_at, input int reset_at,
                        output logic [31:0] res_done, output int done_cyc, output int done_cnt,
                        output int clken_cnt, output int bad_clken, output logic [31:0] res_end,
                        output logic [31:0] k0_ops, output logic [31:0] k3_ops,
                        output logic [31:0] rst_result, output logic [2:0] rst_misc);
    res_done = 32'd0; done_cyc = -1; done_cnt = 0; clken_cnt = 0; bad_clken = 0;
    k0_ops = 32'd0; k3_ops = 32'd0; rst_result = 32'hDEAD_BEEF; rst_misc = 3'b111;
    @(posedge clock); #1;
    dataa = a; datab = b; n = nn; start = 1'b1; clk_en = 1'b1; reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clock); #1;
      start = 1'b0; reset = 1'b0; clk_en = 1'b1;
      if (c >= stall_at && c < stall_at + stall_len) clk_en = 1'b0;
      if (c == busy_at) begin
        start = 1'b1; dataa = 32'h1234_5678; datab = 32'h9ABC_DEF0;
      end
      if (c == reset_at) reset = 1'b1;
      #1;
      if (mul_clken) clken_cnt++;
      if (mul_clken && !clk_en) bad_clken++;
      if (done) begin
        if (done_cnt == 0) begin
          done_cyc = c;
          res_done = result;
        end
        done_cnt++;
      end
      if (c == 1) k0_ops = {mul_dataa, mul_datab};
      if (c == 4) k3_ops = {mul_dataa, mul_datab};
      if (c == reset_at + 1) begin
        rst_result = result;
        rst_misc   = {done, mul_clken, (mul_dataa != 16'd0) || (mul_datab != 16'd0)};
      end
    end
    res_end = result;
  endtask

  logic [31:0] res_done, res_end, k0_ops, k3_ops, rst_result;
  logic [2:0]  rst_misc;
  int          done_cyc, done_cnt, clken_cnt, bad_clken;

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = 32'd0; datab = 32'd0; n = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_clken", 64'(mul_clken), 64'd0);
    check_eq("rst_mul_ops", {32'd0, mul_dataa, mul_datab}, 64'd0);

    // A=0x00010002, B=0x00030004 -> product 0x00000003_000A0008
    run_op(32'h0001_0002, 32'h0003_0004, 2'b00, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("lo_result", 64'(res_done), 64'h000A_0008);
    check_eq("lo_done_cyc", 64'(done_cyc), 64'd7);
    check_eq("lo_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("lo_clken_cnt", 64'(clken_cnt), 64'd6);
    check_eq("lo_k0_ops", 64'(k0_ops), 64'h0002_0004);
    check_eq("lo_k3_ops", 64'(k3_ops), 64'h0001_0003);
    check_eq("lo_result_held", 64'(res_end), 64'h000A_0008);

    run_op(32'h0001_0002, 32'h0003_0004, 2'b01, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("hi_result", 64'(res_done), 64'h0000_0003);
    check_eq("hi_done_cyc", 64'(done_cyc), 64'd7);

    // (2^32-1)^2 = 0xFFFFFFFE_00000001
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("max_hi", 64'(res_done), 64'hFFFF_FFFE);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("max_lo", 64'(res_done), 64'h0000_0001);

    // clk_en low on T+4..T+6 stretches latency by three cycles
    run_op(32'h0001_0002, 32'h0003_0004, 2'b00, 4, 3, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("stall_result", 64'(res_done), 64'h000A_0008);
    check_eq("stall_done_cyc", 64'(done_cyc), 64'd10);
    check_eq("stall_clken_while_low", 64'(bad_clken), 64'd0);
    check_eq("stall_clken_cnt", 64'(clken_cnt), 64'd6);

    // second start at T+3 must be ignored
    run_op(32'h0001_0002, 32'h0003_0004, 2'b00, 0, 0, 3, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("busy_result", 64'(res_done), 64'h000A_0008);
    check_eq("busy_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("busy_done_cyc", 64'(done_cyc), 64'd7);

    // reset at T+4 aborts the operation
    run_op(32'h0001_0002, 32'h0003_0004, 2'b00, 0, 0, 0, 4, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("abort_done_cnt", 64'(done_cnt), 64'd0);
    check_eq("abort_result", 64'(rst_result), 64'd0);
    check_eq("abort_misc", 64'(rst_misc), 64'd0);

    run_op(32'd5, 32'd7, 2'b00, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("post_rst_result", 64'(res_done), 64'd35);
    check_eq("post_rst_done_cyc", 64'(done_cyc), 64'd7);

`ifdef MUL32_SIGNED_EN
    // -1 * 2 = -2 = 0xFFFFFFFF_FFFFFFFE
    run_op(32'hFFFF_FFFF, 32'd2, 2'b11, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("signed_hi", 64'(res_done), 64'hFFFF_FFFF);
    check_eq("signed_done_cyc", 64'(done_cyc), 64'd7);
    run_op(32'hFFFF_FFFF, 32'd2, 2'b10, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("signed_lo", 64'(res_done), 64'hFFFF_FFFE);
`else
    // unsigned (2^32-1)*2 = 0x00000001_FFFFFFFE
    run_op(32'hFFFF_FFFF, 32'd2, 2'b11, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("nosign_hi", 64'(res_done), 64'h0000_0001);
    run_op(32'hFFFF_FFFF, 32'd2, 2'b10, 0, 0, 0, 0, res_done, done_cyc, done_cnt,
           clken_cnt, bad_clken, res_end, k0_ops, k3_ops, rst_result, rst_misc);
    check_eq("nosign_lo", 64'(res_done), 64'hFFFF_FFFE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
